load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits directly upstream of the data memory, between the datapath's memory stage and the word-wide data memory port.
- The memory reads combinationally and writes only whole words at posedge clk when WE is high.
- This block accepts byte, halfword and word load/store requests through a valid/ready handshake.
- Sub-word stores are done as a read-modify-write: read the word, merge the new bytes, write the word back. Loads return the extracted lane, zero-extended, with a one-cycle response pulse.

Parameters:
- AW, 32, width of byte address and of mem_a.
- DW, 32, data width; fixed at 32, with 4 byte lanes.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_op  input  3  operation code: 000 LDR, 001 LDRB, 010 LDRH, 100 STR, 101 STRB, 110 STRH, 011 LDRSB, 111 LDRSH.
- req_addr  input  AW  byte address.
- req_wdata  input  DW  store data; a sub-word store takes its byte/halfword from the low bits.
- resp_valid  output  1  one-cycle pulse marking completion.
- resp_rdata  output  DW  load result; 0 for stores and errors.
- resp_err  output  1  valid together with resp_valid; misaligned access or illegal op.
- mem_a  output  AW  word-aligned address to the data memory (bits [1:0] = 00).
- mem_wd  output  DW  write data to the data memory.
- mem_we  output  1  write enable to the data memory.
- mem_rd  input  DW  combinational read data from the data memory.

Behaviour:
- Reset values (all registered outputs): state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0. mem_a, mem_wd and address/data/op registers clear to 0.
- mem_we is combinational: (state==WRITE) && !reset. A reset asserted during WRITE therefore suppresses that write.
- FSM states: IDLE, ACCESS, WRITE, DONE.
- IDLE:
  - On accept, register op, addr and wdata. Go to ACCESS.
  - If the request is misaligned, go to DONE with err=1 instead. Misaligned means word access with addr[1:0]!=0, or halfword access with addr[0]!=0.
  - An illegal op (signed-load codes when the macro is off) also goes to DONE with err=1.
- ACCESS: mem_a = {addr[AW-1:2],2'b00}.
  - Loads: extract the lane from mem_rd into rdata_q. Go to DONE.
  - STR: mem_wd_q = wdata. Go to WRITE.
  - STRB/STRH: mem_wd_q = mem_rd with the addressed lane(s) replaced by wdata[7:0] / wdata[15:0]. Go to WRITE.
- Lane mapping is little-endian:
  - byte k occupies bits [8k+7:8k], k = addr[1:0];
  - a halfword at addr[1] occupies bits [16*addr[1]+15 : 16*addr[1]].
- WRITE: mem_we=1 and mem_wd = mem_wd_q; the word is written at the posedge leaving this state. Go to DONE.
- DONE: resp_valid=1 for exactly one cycle. Go to IDLE, where req_ready is high again.
- Latency from the accept edge to the resp_valid cycle:
  - loads: 2 cycles;
  - all stores: 3 cycles;
  - errors: 1 cycle.
- Throughput: at most one request in flight. There is no back-pressure on the response side; the consumer must take resp_valid when it pulses.
- req_* inputs are ignored outside IDLE.
- Address upper bits pass through unchanged; wrap-around is the memory's concern.
- Reset in any state returns to IDLE at the next edge. No response is issued for the aborted request.

Optional Feature:
- Macro: LSU_SIGNEXT_EN.
- Defined: ops 011 (LDRSB) and 111 (LDRSH) sign-extend the extracted lane from bit 7 or bit 15. Alignment rules are the same as their unsigned forms.
- Undefined: ops 011 and 111 are illegal. They complete in DONE with resp_err=1 and resp_rdata=0, and memory is never touched.

Decomposition:
- Shared package:
  - op code localparams: OP_LDR, OP_LDRB, OP_LDRH, OP_STR, OP_STRB, OP_STRH, OP_LDRSB, OP_LDRSH;
  - FSM state encodings;
  - size field = op[1:0], store flag = op[2].
- One combinational sub-module, lsu_lane_mux:
  - inputs: word, offset, size, signed, store data;
  - outputs: extracted load value and merged store word.

Test Plan:
- Memory word 0 = 0x11223344. LDRB at addr 0x2 -> resp_rdata=0x00000022 two cycles after accept; resp_err=0.
- STRB wdata=0xAB at addr 0x1 -> mem_we high for exactly one cycle; mem_wd=0x1122AB44. A following LDR at 0x0 returns 0x1122AB44.
- STRH wdata=0xBEEF at addr 0x6 over word 1 = 0xCAFED00D -> word 1 = 0xBEEFD00D. resp_valid arrives 3 cycles after accept.
- LDR at addr 0x3, then STRH at 0x5 -> each gets resp_err=1 one cycle after accept. mem_we never asserts.
- reset asserted in the WRITE cycle of an STR of 0xDEADBEEF to 0x8 -> memory word 2 unchanged, no resp_valid, req_ready=1 on the next cycle.
- Memory word 3 = 0x000080F0, LDRSB at 0xC:
  - with LSU_SIGNEXT_EN: resp_rdata=0xFFFFFFF0;
  - without it: resp_err=1, resp_rdata=0.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: op codes, FSM states, op decode helpers.
// No logic of its own; pure typedefs, constants and combinational helper functions.
// Op field: op[1:0] is the size code, op[2] the store flag, except 2'b11 which marks a signed load.
package load_store_unit_pkg;

    localparam logic [2:0] OP_LDR   = 3'b000;
    localparam logic [2:0] OP_LDRB  = 3'b001;
    localparam logic [2:0] OP_LDRH  = 3'b010;
    localparam logic [2:0] OP_LDRSB = 3'b011;
    localparam logic [2:0] OP_STR   = 3'b100;
    localparam logic [2:0] OP_STRB  = 3'b101;
    localparam logic [2:0] OP_STRH  = 3'b110;
    localparam logic [2:0] OP_LDRSH = 3'b111;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_WRITE  = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    // Size code 2'b11 is shared by the two signed loads; op[2] picks byte or halfword.
    function automatic logic [1:0] op_size(input logic [2:0] op);
        if (op[1:0] == 2'b11) begin
            return op[2] ? SZ_HALF : SZ_BYTE;
        end
        return op[1:0];
    endfunction

    // op[2] marks a store except for LDRSH, which reuses the 2'b11 size code.
    function automatic logic op_is_store(input logic [2:0] op);
        return op[2] && (op[1:0] != 2'b11);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return op[1:0] == 2'b11;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
        return ((size == SZ_WORD) && (offset != 2'b00)) ||
               ((size == SZ_HALF) && offset[0]);
    endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// Byte-lane steering: extracts a little-endian load lane and merges store bytes into a word.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_lane_mux
    import load_store_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = word[{offset, 3'b000} +: 8];
    assign half_lane = word[{offset[1], 4'b0000} +: 16];

    // Load extraction: select the addressed lane, then zero- or sign-extend it.
    always_comb begin
        load_data = word;
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            SZ_HALF: load_data = {{16{sign_ext & half_lane[15]}}, half_lane};
            default: load_data = word;
        endcase
    end

    // Store merge: keep the old word and overwrite only the addressed lane(s).
    always_comb begin
        merged_word = word;
        case (size)
            SZ_BYTE: merged_word[{offset, 3'b000} +: 8]     = store_data[7:0];
            SZ_HALF: merged_word[{offset[1], 4'b0000} +: 16] = store_data[15:0];
            default: merged_word = store_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-wide memory; sub-word stores by read-modify-write.
// Latency accept->resp_valid: error 1, load 2, store 3 cycles; one request in flight.
// req_ready only in IDLE; resp_valid is a single-cycle pulse with no backpressure.
// LSU_SIGNEXT_EN: when defined, LDRSB/LDRSH sign-extend; otherwise they complete with resp_err.
module load_store_unit #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd
);

    import load_store_unit_pkg::*;

    state_t        state;
    state_t        next_state;
    logic [2:0]    op_q;
    logic [1:0]    off_q;
    logic [DW-1:0] wdata_q;
    logic          accept;
    logic          op_illegal;
    logic          req_bad;
    logic          lane_sign;
    logic [DW-1:0] load_data;
    logic [DW-1:0] merged_word;

    assign accept = req_valid && req_ready;

`ifdef LSU_SIGNEXT_EN
    assign op_illegal = 1'b0;
    assign lane_sign  = op_is_signed(op_q);
`else
    assign op_illegal = op_is_signed(req_op);
    assign lane_sign  = 1'b0;
`endif

    assign req_bad = op_illegal || misaligned(op_size(req_op), req_addr[1:0]);

    lsu_lane_mux u_lane_mux (
        .word        (mem_rd),
        .offset      (off_q),
        .size        (op_size(op_q)),
        .sign_ext    (lane_sign),
        .store_data  (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // State register; reset from any state aborts the request silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: bad requests skip straight to DONE, stores take the extra WRITE cycle.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (accept) next_state = req_bad ? ST_DONE : ST_ACCESS;
            ST_ACCESS: next_state = op_is_store(op_q) ? ST_WRITE : ST_DONE;
            ST_WRITE:  next_state = ST_DONE;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; reset gates the write so an aborted store never lands.
    always_comb begin
        req_ready = (state == ST_IDLE);
        mem_we    = (state == ST_WRITE) && !reset;
    end

    // Response pulse is registered so it is high exactly for the DONE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
        end else begin
            resp_valid <= (next_state == ST_DONE);
        end
    end

    // Request capture on accept; load lane or merged store word captured in ACCESS.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= '0;
            off_q      <= '0;
            wdata_q    <= '0;
            mem_a      <= '0;
            mem_wd     <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            op_q       <= req_op;
            off_q      <= req_addr[1:0];
            wdata_q    <= req_wdata;
            mem_a      <= {req_addr[AW-1:2], 2'b00};
            resp_rdata <= '0;
            resp_err   <= req_bad;
        end else if (state == ST_ACCESS) begin
            if (op_is_store(op_q)) begin
                mem_wd <= merged_word;
            end else begin
                resp_rdata <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-level reference memory and response scoreboard.
// Expected responses are queued at request time and popped when resp_valid pulses.
// Honours LSU_SIGNEXT_EN the same way as the design.
module tb_load_store_unit;

    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    always #5 clk = ~clk;

    load_store_unit #(.AW(32), .DW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    // Data memory seen by the DUT, and an independent reference copy.
    logic [31:0] mem     [0:15];
    logic [31:0] ref_mem [0:15];

    assign mem_rd = mem[mem_a[5:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_a[5:2]] <= mem_wd;
    end

    int cyc      = 0;
    int acc_cyc  = 0;
    int we_count = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready && !reset) acc_cyc <= cyc + 1;
        if (mem_we) we_count <= we_count + 1;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Response monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", {31'b0, resp_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rdata", resp_rdata, e.rdata);
                check("err", {31'b0, resp_err}, {31'b0, e.err});
                check("latency", cyc - acc_cyc + 1, e.lat);
            end
        end
    end

    // Reference behaviour in byte/shift arithmetic; updates ref_mem for stores.
    task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output exp_t e, output int wr);
        logic [31:0] w;
        logic [31:0] lane;
        logic [31:0] mask;
        int          sh;
        logic        bad;
        w = ref_mem[addr[5:2]];
        sh = int'(addr[1:0]) * 8;
        e.rdata = 32'd0;
        e.err = 1'b0;
        e.lat = 2;
        wr = 0;
        bad = 1'b0;
        lane = 32'd0;
        mask = 32'd0;
        case (op)
            OP_LDR:  if (addr[1:0] != 2'b00) bad = 1'b1; else e.rdata = w;
            OP_LDRB: e.rdata = (w >> sh) & 32'hFF;
            OP_LDRH: if (addr[0]) bad = 1'b1; else e.rdata = (w >> sh) & 32'hFFFF;
            OP_STR: begin
                if (addr[1:0] != 2'b00) bad = 1'b1;
                else begin ref_mem[addr[5:2]] = wd; wr = 1; e.lat = 3; end
            end
            OP_STRB: begin
                mask = 32'hFF << sh;
                ref_mem[addr[5:2]] = (w & ~mask) | ((wd & 32'hFF) << sh);
                wr = 1; e.lat = 3;
            end
            OP_STRH: begin
                if (addr[0]) bad = 1'b1;
                else begin
                    mask = 32'hFFFF << sh;
                    ref_mem[addr[5:2]] = (w & ~mask) | ((wd & 32'hFFFF) << sh);
                    wr = 1; e.lat = 3;
                end
            end
            OP_LDRSB: begin
`ifdef LSU_SIGNEXT_EN
                lane = (w >> sh) & 32'hFF;
                if (lane[7]) lane = lane | 32'hFFFFFF00;
                e.rdata = lane;
`else
                bad = 1'b1;
`endif
            end
            default: begin // OP_LDRSH
`ifdef LSU_SIGNEXT_EN
                if (addr[0]) bad = 1'b1;
                else begin
                    lane = (w >> sh) & 32'hFFFF;
                    if (lane[15]) lane = lane | 32'hFFFF0000;
                    e.rdata = lane;
                end
`else
                bad = 1'b1;
`endif
            end
        endcase
        if (bad) begin
            e.rdata = 32'd0;
            e.err = 1'b1;
            e.lat = 1;
            wr = 0;
        end
    endtask

    // One complete transaction: queue expectation, handshake, wait for the response, check memory.
    task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int   wr;
        int   we0;
        int   n;
        model(op, addr, wd, e, wr);
        we0 = we_count;
        @(negedge clk);
        req_op = op;
        req_addr = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("resp_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        @(negedge clk);
        check("we_count", we_count - we0, wr);
        check("mem_word", mem[addr[5:2]], ref_mem[addr[5:2]]);
    endtask

    initial begin
        int we0;
        for (int i = 0; i < 16; i++) begin
            mem[i] = 32'h01010101 * i;
        end
        mem[0] = 32'h11223344;
        mem[1] = 32'hCAFED00D;
        mem[2] = 32'h01020304;
        mem[3] = 32'h000080F0;
        for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];

        reset = 1'b1;
        req_valid = 1'b0;
        req_op = 3'b000;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);

        // Directed cases.
        do_req(OP_LDRB, 32'h2, 32'h0);
        do_req(OP_STRB, 32'h1, 32'hFFFFFFAB);
        do_req(OP_LDR,  32'h0, 32'h0);
        do_req(OP_STRH, 32'h6, 32'h1234BEEF);
        do_req(OP_LDR,  32'h4, 32'h0);
        do_req(OP_LDR,  32'h3, 32'h0);
        do_req(OP_STRH, 32'h5, 32'h5555);
        do_req(OP_LDRH, 32'hE, 32'h0);
        do_req(OP_LDRB, 32'h3, 32'h0);
        do_req(OP_STRB, 32'hB, 32'h77);
        do_req(OP_STR,  32'h14, 32'hA5A5_5A5A);

        // Reset landing in the WRITE cycle of a word store must suppress it.
        we0 = we_count;
        @(negedge clk);
        req_op = OP_STR;
        req_addr = 32'h8;
        req_wdata = 32'hDEADBEEF;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("we_in_write", {31'b0, mem_we}, 32'd1);
        reset = 1'b1;
        #1;
        check("we_gated_by_reset", {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("ready_after_reset", {31'b0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        check("reset_we_count", we_count - we0, 32'd0);
        check("reset_mem_word2", mem[2], ref_mem[2]);

        // Signed loads (legal or illegal depending on the build).
        do_req(OP_LDRSB, 32'hC, 32'h0);
        do_req(OP_LDRSH, 32'hC, 32'h0);
        do_req(OP_LDRSH, 32'hD, 32'h0);

        // Random mix over the 16-word window.
        for (int i = 0; i < 30; i++) begin
            do_req(3'($urandom_range(0, 7)), 32'($urandom_range(0, 63)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
